mem_traffic_gen: RTL

MEM_TRAFFIC_GEN -- requirements
Module: mem_traffic_gen

---
 rtl/mem_traffic_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_traffic_gen.sv
// Memory test sequencer: writes an address^seed pattern over a window, reads it back and
// compares each word. Results are held until the next start.
module mem_traffic_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int READ_LATENCY  = 1,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-1:0] word_count,
  input  logic [DATA_WIDTH-1:0]    seed,
  output logic                     cs,
  output logic                     we,
  output logic                     oe,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_WIDTH-1:0]     err_count,
  output logic [ADDRESS_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] A_ONE      = ADDRESS_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]     E_ONE      = ERR_WIDTH'(1);
  localparam logic [2:0]               DRAIN_LAST = 3'(READ_LATENCY - 1);

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDRESS_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0]    s);
    return DATA_WIDTH'(a) ^ s;
  endfunction

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] base_q, count_q, idx;
  logic [DATA_WIDTH-1:0]    seed_q;
  logic [2:0]               drain_cnt;
  logic                     last_word;

  assign last_word = (idx == count_q - A_ONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_count == '0) ? FINISH : WRITE;
      WRITE:   if (last_word) state_nxt = READ;
      READ:    if (last_word) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = FINISH;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered memory-side and status outputs.
  logic                     cs_n, we_n, oe_n, busy_n, done_n;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0]    wdat_n, seed_cur;

  assign seed_cur = (state == IDLE) ? seed : seed_q;

  always_comb begin
    cs_n   = 1'b0;
    we_n   = 1'b0;
    oe_n   = 1'b0;
    addr_n = address;
    wdat_n = wr_data;
    busy_n = (state_nxt == WRITE) || (state_nxt == READ) || (state_nxt == DRAIN);
    done_n = (state_nxt == FINISH);
    case (state_nxt)
      WRITE: begin
        cs_n   = 1'b1;
        we_n   = 1'b1;
        addr_n = (state == IDLE) ? base_addr : address + A_ONE;
        wdat_n = pattern(addr_n, seed_cur);
      end
      READ: begin
        cs_n   = 1'b1;
        oe_n   = 1'b1;
        addr_n = (state == WRITE) ? base_q : address + A_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs <= 1'b0; we <= 1'b0; oe <= 1'b0;
      address <= '0; wr_data <= '0;
      busy <= 1'b0; done <= 1'b0;
    end else begin
      cs <= cs_n; we <= we_n; oe <= oe_n;
      address <= addr_n; wr_data <= wdat_n;
      busy <= busy_n; done <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0; count_q <= '0; seed_q <= '0;
      idx <= '0; drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            seed_q  <= seed;
          end
          idx       <= '0;
          drain_cnt <= '0;
        end
        WRITE, READ: idx <= last_word ? '0 : idx + A_ONE;
        DRAIN:       drain_cnt <= drain_cnt + 3'd1;
        default: begin
          idx       <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Expected data rides alongside each read request until the memory answers.
  logic                     pipe_vld  [READ_LATENCY];
  logic [ADDRESS_WIDTH-1:0] pipe_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]    pipe_exp  [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld[k]  <= 1'b0;
        pipe_addr[k] <= '0;
        pipe_exp[k]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= cs & oe & ~we;
      pipe_addr[0] <= address;
      pipe_exp[0]  <= pattern(address, seed_q);
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
      end
    end
  end

  logic                 mismatch, run_start;
  logic [ERR_WIDTH-1:0] err_nxt;

  assign run_start = (state == IDLE) && start;
  assign mismatch  = pipe_vld[READ_LATENCY-1] && (rd_data != pipe_exp[READ_LATENCY-1]);

  always_comb begin
    err_nxt = err_count;
    if (run_start)                      err_nxt = '0;
    else if (mismatch && (err_count != '1)) err_nxt = err_count + E_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0; fail_addr <= '0; fail_data <= '0; pass <= 1'b0;
    end else begin
      err_count <= err_nxt;
      if (run_start) begin
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mismatch && (err_count == '0)) begin
        fail_addr <= pipe_addr[READ_LATENCY-1];
        fail_data <= rd_data;
      end
      if (state_nxt == FINISH) pass <= (err_nxt == '0);
      else if (run_start)      pass <= 1'b0;
    end
  end

endmodule
